// File: rtl/types_pkg.sv
// Shared types for the strategy FSMs and the strategy switch: strategy ids,
// the output bundle every strategy FSM drives, and the switch FSM states.
package types_pkg;

    typedef enum logic [2:0] {
        SELF_TEST   = 3'd0,
        CALIBRATION = 3'd1,
        ACQUIRE     = 3'd2,
        TRACK       = 3'd3,
        HOLDOVER    = 3'd4
    } variants_t;

    // Number of members in variants_t; keep in step with the enum above.
    localparam int STRATEGY_NUM = 5;

    typedef struct packed {
        logic       pulse;
        logic       pulse_en;
        logic [1:0] edge_sel;
        logic [7:0] phase_step;
    } output_signals_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        BLANK = 2'd2
    } switch_state_t;

endpackage

// File: rtl/strategy_out_sel.sv
// Registered N:1 selector of strategy output bundles; blank forces the
// registered output to all zeros.
module strategy_out_sel
    import types_pkg::*;
#(
    parameter int NUM_INPUTS = STRATEGY_NUM
) (
    input  logic            clock,
    input  logic            reset,
    input  variants_t       sel,
    input  logic            blank,
    input  output_signals_t in_n [NUM_INPUTS],
    output output_signals_t out
);

    output_signals_t picked;

    // Compare-and-pick loop keeps the index width independent of NUM_INPUTS.
    always_comb begin
        picked = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (int'(sel) == i) begin
                picked = in_n[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out <= '0;
        end else if (blank) begin
            out <= '0;
        end else begin
            out <= picked;
        end
    end

endmodule

// File: rtl/strategy_switch.sv
// Controlled switch between NUM_STRATEGIES strategy FSMs: drain, blank, restart.
// Optional drain timeout is enabled by defining STRATEGY_SWITCH_TIMEOUT_EN.
module strategy_switch
    import types_pkg::*;
#(
    parameter int        NUM_STRATEGIES   = STRATEGY_NUM,
    parameter variants_t DEFAULT_STRATEGY = SELF_TEST,
    parameter int        BLANK_CYCLES     = 4,
    parameter int        DRAIN_TIMEOUT    = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  variants_t                 strategy_req,
    input  output_signals_t           out_n [NUM_STRATEGIES],
    input  logic [NUM_STRATEGIES-1:0] idle_n,
    output output_signals_t           out,
    output logic [NUM_STRATEGIES-1:0] fsm_reset,
    output variants_t                 strategy_active,
    output logic                      busy,
    output logic                      switch_done,
    output logic                      err_invalid,
    output logic                      err_timeout
);

    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [NUM_STRATEGIES-1:0] DEFAULT_RELEASE =
        ~(NUM_STRATEGIES'(1) << DEFAULT_STRATEGY);

    if (NUM_STRATEGIES < 2 || NUM_STRATEGIES > 8) begin : g_bad_num
        $error("strategy_switch: NUM_STRATEGIES must be within 2..8");
    end
    if (int'(DEFAULT_STRATEGY) >= NUM_STRATEGIES) begin : g_bad_default
        $error("strategy_switch: DEFAULT_STRATEGY out of range");
    end
    if (BLANK_CYCLES < 1 || DRAIN_TIMEOUT < 1) begin : g_bad_count
        $error("strategy_switch: BLANK_CYCLES and DRAIN_TIMEOUT must be >= 1");
    end

    switch_state_t             state, state_nx;
    variants_t                 active, active_nx;
    variants_t                 target, target_nx;
    variants_t                 prev_req;
    logic [BLANK_W-1:0]        blank_cnt, blank_cnt_nx;
    logic [NUM_STRATEGIES-1:0] fsm_reset_q, fsm_reset_nx;
    logic                      req_valid;
    logic                      req_new;
    logic                      idle_active;
    logic                      drain_expired;
    logic                      done_nx;

    assign req_valid = int'(strategy_req) < NUM_STRATEGIES;
    assign req_new   = strategy_req != active;

    always_comb begin
        idle_active = 1'b0;
        for (int i = 0; i < NUM_STRATEGIES; i++) begin
            if (int'(active) == i) begin
                idle_active = idle_n[i];
            end
        end
    end

`ifdef STRATEGY_SWITCH_TIMEOUT_EN
    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_TIMEOUT);

    logic [DRAIN_W-1:0] drain_cnt;

    // Expire on the DRAIN cycle whose decrement reaches 0, bounding DRAIN to DRAIN_TIMEOUT cycles.
    assign drain_expired = drain_cnt <= DRAIN_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            drain_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == RUN) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            err_timeout <= (state == DRAIN) && req_new && !idle_active && drain_expired;
        end
    end
`else
    assign drain_expired = 1'b0;
    assign err_timeout   = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_nx     = state;
        active_nx    = active;
        target_nx    = target;
        blank_cnt_nx = blank_cnt;
        done_nx      = 1'b0;
        case (state)
            RUN: begin
                if (req_valid && req_new) begin
                    target_nx = strategy_req;
                    state_nx  = DRAIN;
                end
            end
            DRAIN: begin
                if (req_valid) begin
                    target_nx = strategy_req;
                end
                // Abort has priority over idle/timeout in the same cycle.
                if (!req_new) begin
                    state_nx = RUN;
                end else if (idle_active || drain_expired) begin
                    state_nx     = BLANK;
                    blank_cnt_nx = BLANK_LOAD;
                end
            end
            BLANK: begin
                if (blank_cnt == '0) begin
                    active_nx = target;
                    state_nx  = RUN;
                    done_nx   = 1'b1;
                end else begin
                    blank_cnt_nx = blank_cnt - 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // fsm_reset is registered from next-state values so it changes with the state.
    always_comb begin
        fsm_reset_nx = '1;
        if (state_nx != BLANK) begin
            for (int i = 0; i < NUM_STRATEGIES; i++) begin
                if (int'(active_nx) == i) begin
                    fsm_reset_nx[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state       <= RUN;
            active      <= DEFAULT_STRATEGY;
            target      <= DEFAULT_STRATEGY;
            prev_req    <= DEFAULT_STRATEGY;
            blank_cnt   <= '0;
            fsm_reset_q <= DEFAULT_RELEASE;
            switch_done <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            state       <= state_nx;
            active      <= active_nx;
            target      <= target_nx;
            prev_req    <= strategy_req;
            blank_cnt   <= blank_cnt_nx;
            fsm_reset_q <= fsm_reset_nx;
            switch_done <= done_nx;
            err_invalid <= !req_valid && (strategy_req != prev_req);
        end
    end

    // Holding all FSMs in reset while reset is high; the register supplies the rest.
    assign fsm_reset       = fsm_reset_q | {NUM_STRATEGIES{reset}};
    assign busy            = state != RUN;
    assign strategy_active = active;

    strategy_out_sel #(
        .NUM_INPUTS (NUM_STRATEGIES)
    ) u_out_sel (
        .clock (clock),
        .reset (reset),
        .sel   (active),
        .blank (state == BLANK),
        .in_n  (out_n),
        .out   (out)
    );

endmodule

// File: tb/tb_strategy_switch.sv
// Self-checking bench for strategy_switch: random bundles and switch timings
// checked against a timeline model derived from the switch timing rules.
module tb_strategy_switch;
    import types_pkg::*;

    localparam int N    = 5;
    localparam int B    = 4;
    localparam int DT   = 8;
    localparam int OS_W = $bits(output_signals_t);

    logic            clock = 1'b0;
    logic            reset;
    variants_t       strategy_req;
    output_signals_t out_n [N];
    logic [N-1:0]    idle_n;
    output_signals_t out;
    logic [N-1:0]    fsm_reset;
    variants_t       strategy_active;
    logic            busy;
    logic            switch_done;
    logic            err_invalid;
    logic            err_timeout;

    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              model_active = 0;
    output_signals_t prev_n [N];

    always #5 clock = ~clock;

    strategy_switch #(
        .NUM_STRATEGIES   (N),
        .DEFAULT_STRATEGY (SELF_TEST),
        .BLANK_CYCLES     (B),
        .DRAIN_TIMEOUT    (DT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .strategy_req    (strategy_req),
        .out_n           (out_n),
        .idle_n          (idle_n),
        .out             (out),
        .fsm_reset       (fsm_reset),
        .strategy_active (strategy_active),
        .busy            (busy),
        .switch_done     (switch_done),
        .err_invalid     (err_invalid),
        .err_timeout     (err_timeout)
    );

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive_outputs();
        for (int i = 0; i < N; i++) begin
            out_n[i] = output_signals_t'(OS_W'($urandom));
        end
    endtask

    function automatic variants_t to_var(input int v);
        return variants_t'(3'(v));
    endfunction

    function automatic logic [N-1:0] rel_mask(input int idx);
        logic [N-1:0] m;
        m = '1;
        m[idx[2:0]] = 1'b0;
        return m;
    endfunction

    function automatic int pick_other(input int cur);
        int v;
        do v = int'($urandom_range(N - 1)); while (v == cur);
        return v;
    endfunction

    task automatic test_reset();
        reset        = 1'b1;
        strategy_req = SELF_TEST;
        idle_n       = '1;
        drive_outputs();
        step();
        step();
        total++;
        if (fsm_reset !== '1) begin
            bad++;
            $display("FAIL rst_hold_fsm_reset got=%b exp=%b", fsm_reset, {N{1'b1}});
        end
        reset = 1'b0;
        #1;
        total++;
        if (fsm_reset !== 5'b11110) begin
            bad++;
            $display("FAIL rst_fsm_reset got=%b exp=11110", fsm_reset);
        end
        total++;
        if (strategy_active !== SELF_TEST || out !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_state active=%0d out=%h busy=%b exp=0/0/0",
                     strategy_active, out, busy);
        end
        total++;
        if (switch_done !== 1'b0 || err_invalid !== 1'b0 || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL rst_pulses done=%b inv=%b to=%b exp=0", switch_done, err_invalid, err_timeout);
        end
        drive_outputs();
        for (int k = 0; k < 3; k++) begin
            prev_n = out_n;
            step();
            total++;
            if (out !== prev_n[0] || fsm_reset !== 5'b11110) begin
                bad++;
                $display("FAIL rst_follow out=%h exp=%h fsm_reset=%b", out, prev_n[0], fsm_reset);
            end
            drive_outputs();
        end
        model_active = 0;
    endtask

    // Switch from model_active: 'first' requested in the request cycle, 'nw' afterwards.
    task automatic test_switch(input int first, input int nw, input int d, input bit timeout_mode);
        int              old, r, e, s, exp_act;
        output_signals_t exp_out;
        logic [N-1:0]    exp_rst;
        logic            exp_busy, exp_done, exp_to;
        old = model_active;
        r   = cyc;
        e   = r + 1 + d + B;
        strategy_req = to_var(first);
        idle_n       = N'($urandom);
        idle_n[old]  = 1'b0;
        drive_outputs();
        for (int c = r + 1; c <= e + 2; c++) begin
            prev_n = out_n;
            step();
            s = c - 1;
            if (s <= r + d)          exp_out = prev_n[old];
            else if (s <= r + d + B) exp_out = '0;
            else                     exp_out = prev_n[nw];
            exp_busy = (c >= r + 1) && (c <= r + d + B);
            exp_done = (c == e);
            exp_to   = timeout_mode && (c == r + d + 1);
            exp_act  = (c >= e) ? nw : old;
            if (c >= e)         exp_rst = rel_mask(nw);
            else if (c > r + d) exp_rst = '1;
            else                exp_rst = rel_mask(old);
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL sw_out cyc=%0d got=%h exp=%h", c - r, out, exp_out);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL sw_busy cyc=%0d got=%b exp=%b", c - r, busy, exp_busy);
            end
            total++;
            if (switch_done !== exp_done) begin
                bad++;
                $display("FAIL sw_done cyc=%0d got=%b exp=%b", c - r, switch_done, exp_done);
            end
            total++;
            if (int'(strategy_active) !== exp_act) begin
                bad++;
                $display("FAIL sw_active cyc=%0d got=%0d exp=%0d", c - r, strategy_active, exp_act);
            end
            total++;
            if (fsm_reset !== exp_rst) begin
                bad++;
                $display("FAIL sw_fsm_reset cyc=%0d got=%b exp=%b", c - r, fsm_reset, exp_rst);
            end
            total++;
            if (err_timeout !== exp_to || err_invalid !== 1'b0) begin
                bad++;
                $display("FAIL sw_err cyc=%0d to=%b exp_to=%b inv=%b", c - r, err_timeout, exp_to, err_invalid);
            end
            strategy_req = to_var(nw);
            idle_n       = N'($urandom);
            if (c < e) idle_n[old] = !timeout_mode && (c >= r + d);
            drive_outputs();
        end
        model_active = nw;
    endtask

    // Request another strategy, then return to the active one after n DRAIN cycles.
    task automatic test_abort(input int n, input bit idle_at_abort);
        int old, x, r;
        old = model_active;
        x   = pick_other(old);
        r   = cyc;
        strategy_req = to_var(x);
        idle_n       = N'($urandom);
        idle_n[old]  = 1'b0;
        drive_outputs();
        for (int c = r + 1; c <= r + n + 3; c++) begin
            prev_n = out_n;
            step();
            total++;
            if (busy !== (c <= r + n)) begin
                bad++;
                $display("FAIL abort_busy cyc=%0d got=%b exp=%b", c - r, busy, (c <= r + n));
            end
            total++;
            if (out !== prev_n[old] || fsm_reset !== rel_mask(old)) begin
                bad++;
                $display("FAIL abort_out cyc=%0d out=%h exp=%h fsm_reset=%b exp=%b",
                         c - r, out, prev_n[old], fsm_reset, rel_mask(old));
            end
            total++;
            if (switch_done !== 1'b0 || int'(strategy_active) !== old) begin
                bad++;
                $display("FAIL abort_state cyc=%0d done=%b active=%0d exp=0/%0d",
                         c - r, switch_done, strategy_active, old);
            end
            strategy_req = to_var((c >= r + n) ? old : x);
            idle_n       = N'($urandom);
            if (c < r + n)       idle_n[old] = 1'b0;
            else if (c == r + n) idle_n[old] = idle_at_abort;
            drive_outputs();
        end
    endtask

    task automatic test_invalid();
        int old, r, cur, last, v;
        logic exp_err;
        old  = model_active;
        last = old;
        cur  = 7;
        r    = cyc;
        strategy_req = to_var(cur);
        idle_n       = '1;
        drive_outputs();
        for (int c = r + 1; c <= r + 24; c++) begin
            prev_n = out_n;
            step();
            exp_err = (cur >= N) && (cur != last);
            total++;
            if (err_invalid !== exp_err) begin
                bad++;
                $display("FAIL inv_pulse cyc=%0d req=%0d got=%b exp=%b", c - r, cur, err_invalid, exp_err);
            end
            total++;
            if (busy !== 1'b0 || int'(strategy_active) !== old || fsm_reset !== rel_mask(old)) begin
                bad++;
                $display("FAIL inv_state cyc=%0d busy=%b active=%0d fsm_reset=%b exp=0/%0d",
                         c - r, busy, strategy_active, fsm_reset, old);
            end
            total++;
            if (out !== prev_n[old]) begin
                bad++;
                $display("FAIL inv_out cyc=%0d got=%h exp=%h", c - r, out, prev_n[old]);
            end
            last = cur;
            if (c - r == 1)      cur = 7;
            else if (c - r == 2) cur = 6;
            else begin
                v   = int'($urandom_range(3));
                cur = (v == 0) ? old : N - 1 + v;
            end
            strategy_req = to_var(cur);
            drive_outputs();
        end
        strategy_req = to_var(old);
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int nw, first;
        for (int k = 0; k < 6; k++) begin
            nw    = pick_other(model_active);
            first = ($urandom_range(1) == 1) ? pick_other(model_active) : nw;
            test_switch(first, nw, int'($urandom_range(6, 1)), 1'b0);
        end
    endtask

    task automatic test_timeout();
`ifdef STRATEGY_SWITCH_TIMEOUT_EN
        int nw;
        nw = pick_other(model_active);
        test_switch(nw, nw, DT, 1'b1);
`else
        int old, nw, r;
        logic got;
        old = model_active;
        nw  = pick_other(old);
        r   = cyc;
        strategy_req = to_var(nw);
        idle_n       = '0;
        drive_outputs();
        for (int c = r + 1; c <= r + 100; c++) begin
            prev_n = out_n;
            step();
            total++;
            if (busy !== 1'b1 || switch_done !== 1'b0 || err_timeout !== 1'b0) begin
                bad++;
                $display("FAIL hold_flags cyc=%0d busy=%b done=%b to=%b exp=1/0/0",
                         c - r, busy, switch_done, err_timeout);
            end
            total++;
            if (out !== prev_n[old] || int'(strategy_active) !== old || fsm_reset !== rel_mask(old)) begin
                bad++;
                $display("FAIL hold_state cyc=%0d out=%h exp=%h active=%0d fsm_reset=%b",
                         c - r, out, prev_n[old], strategy_active, fsm_reset);
            end
            drive_outputs();
        end
        idle_n = '1;
        got    = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = switch_done;
        end
        total++;
        if (got !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got_done=%b exp=1 within 20 cycles", got);
        end
        step();
        total++;
        if (int'(strategy_active) !== nw || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_final active=%0d busy=%b exp=%0d/0", strategy_active, busy, nw);
        end
        model_active = nw;
`endif
    endtask

    task automatic test_reset_mid_blank();
        int old, nw, r;
        if (model_active == 0) test_switch(2, 2, 1, 1'b0);
        old = model_active;
        nw  = pick_other(old);
        r   = cyc;
        strategy_req = to_var(nw);
        idle_n       = '1;
        drive_outputs();
        for (int c = r + 1; c <= r + 3; c++) begin
            prev_n = out_n;
            step();
            total++;
            if (busy !== 1'b1 || fsm_reset !== ((c >= r + 2) ? {N{1'b1}} : rel_mask(old))) begin
                bad++;
                $display("FAIL mid_pre cyc=%0d busy=%b fsm_reset=%b", c - r, busy, fsm_reset);
            end
            drive_outputs();
        end
        reset        = 1'b1;
        strategy_req = SELF_TEST;
        #1;
        total++;
        if (fsm_reset !== '1) begin
            bad++;
            $display("FAIL mid_rst_hold fsm_reset=%b exp=%b", fsm_reset, {N{1'b1}});
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if (int'(strategy_active) !== 0 || busy !== 1'b0 || out !== '0 || switch_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_after active=%0d busy=%b out=%h done=%b exp=0/0/0/0",
                     strategy_active, busy, out, switch_done);
        end
        total++;
        if (fsm_reset !== rel_mask(0)) begin
            bad++;
            $display("FAIL mid_fsm_reset got=%b exp=%b", fsm_reset, rel_mask(0));
        end
        drive_outputs();
        for (int k = 0; k < 4; k++) begin
            prev_n = out_n;
            step();
            total++;
            if (out !== prev_n[0] || int'(strategy_active) !== 0 || busy !== 1'b0 || switch_done !== 1'b0) begin
                bad++;
                $display("FAIL mid_run k=%0d out=%h exp=%h active=%0d busy=%b done=%b",
                         k, out, prev_n[0], strategy_active, busy, switch_done);
            end
            drive_outputs();
        end
        model_active = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_switch(1, 1, 1, 1'b0);
        test_abort(3, 1'b0);
        test_abort(2, 1'b1);
        test_invalid();
        test_back_to_back();
        test_timeout();
        test_reset_mid_blank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
